// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-address sequencer: state encoding and default vectors.
// Pure declarations; no logic, latency or flow control of its own.
package pc_seq_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DSLOT = 1'b1
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h8000_0180;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; push/pop take effect at the next edge, top is combinational.
// No backpressure: a push when full overwrites the oldest entry, a pop must only be issued when count>0.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [PC_W-1:0]            push_data,
  input  logic                       pop,
  output logic [PC_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int               PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] tp_q, tp_d, wr_idx;
  logic [PTR_W:0]   count_q, count_d;

  // Push+pop together: the pop consumes the old top and the push refills the same slot.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    wr_idx  = tp_q + PTR_W'(1);
    case ({push, pop})
      2'b10: begin
        tp_d    = tp_q + PTR_W'(1);
        count_d = (count_q == FULL) ? count_q : count_q + (PTR_W+1)'(1);
      end
      2'b01: begin
        tp_d    = tp_q - PTR_W'(1);
        count_d = count_q - (PTR_W+1)'(1);
      end
      2'b11: wr_idx = tp_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q    <= '0;
      count_q <= '0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= push_data;
  end

  assign top   = mem_q[tp_q];
  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// MIPS32 fetch PC sequencer with delay-slot redirects, exception entry/return and RAS; 1-cycle latency.
// stall holds all state (exceptions and eret still act); requesters must hold requests while stalled.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_EXC_VEC,
  parameter int              INC       = PC_INC,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_target,
  input  logic                       redirect_delay,
  input  logic                       call_push,
  input  logic                       ret_pop,
  input  logic                       exc_valid,
  input  logic                       eret,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            epc,
  output logic                       epc_bd,
  output logic                       in_dslot,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_underflow,
  output logic                       redirect_err
);

  localparam logic [PC_W-1:0] STEP  = PC_W'(INC);
  localparam logic [PC_W-1:0] STEP2 = PC_W'(2 * INC);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            epc_bd_q, epc_bd_d;
  logic            in_dslot_q, in_dslot_d;
  logic            ras_underflow_q, ras_underflow_d;
  logic            redirect_err_q, redirect_err_d;

  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  logic [PC_W-1:0] pc_seq;

  assign pc_seq = pc_q + STEP;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_tgt_d      = pend_tgt_q;
    epc_d           = epc_q;
    epc_bd_d        = epc_bd_q;
    ras_underflow_d = 1'b0;
    redirect_err_d  = 1'b0;
    ras_push        = 1'b0;
    ras_pop         = 1'b0;

    if (exc_valid) begin
      // In a delay slot the restart point is the branch itself, one slot back.
      epc_d    = (state_q == DSLOT) ? pc_q - STEP : pc_q;
      epc_bd_d = (state_q == DSLOT);
      pc_d     = EXC_VEC;
      state_d  = RUN;
    end else if (eret) begin
      pc_d    = epc_q;
      state_d = RUN;
    end else if (!stall) begin
      ras_push = call_push;
      if (state_q == DSLOT) begin
        pc_d           = pend_tgt_q;
        state_d        = RUN;
        redirect_err_d = redirect_valid | ret_pop;
      end else if (redirect_valid) begin
        if (redirect_delay) begin
          pc_d       = pc_seq;
          pend_tgt_d = redirect_target;
          state_d    = DSLOT;
        end else begin
          pc_d = redirect_target;
        end
      end else if (ret_pop) begin
        pc_d = pc_seq;
        if (ras_cnt != '0) begin
          ras_pop    = 1'b1;
          pend_tgt_d = ras_top;
          state_d    = DSLOT;
        end else begin
          ras_underflow_d = 1'b1;
        end
      end else begin
        pc_d = pc_seq;
      end
    end

    in_dslot_d = (state_d == DSLOT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      pc_q            <= RESET_VEC;
      pend_tgt_q      <= '0;
      epc_q           <= '0;
      epc_bd_q        <= 1'b0;
      in_dslot_q      <= 1'b0;
      ras_underflow_q <= 1'b0;
      redirect_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_tgt_q      <= pend_tgt_d;
      epc_q           <= epc_d;
      epc_bd_q        <= epc_bd_d;
      in_dslot_q      <= in_dslot_d;
      ras_underflow_q <= ras_underflow_d;
      redirect_err_q  <= redirect_err_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .push_data (pc_q + STEP2),
    .pop       (ras_pop),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign epc_bd        = epc_bd_q;
  assign in_dslot      = in_dslot_q;
  assign ras_count     = ras_cnt;
  assign ras_underflow = ras_underflow_q;
  assign redirect_err  = redirect_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, redirect_delay, call_push, ret_pop, exc_valid, eret;
  logic [31:0] redirect_target;
  logic [31:0] pc, epc;
  logic        epc_bd, in_dslot, ras_underflow, redirect_err;
  logic [2:0]  ras_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural view only.
  logic [31:0] m_pc, m_epc, m_tgt;
  logic        m_bd, m_pend, m_uf, m_err;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W      (32),
    .RESET_VEC (32'h0),
    .EXC_VEC   (EXC),
    .INC       (4),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .redirect_delay  (redirect_delay),
    .call_push       (call_push),
    .ret_pop         (ret_pop),
    .exc_valid       (exc_valid),
    .eret            (eret),
    .pc              (pc),
    .epc             (epc),
    .epc_bd          (epc_bd),
    .in_dslot        (in_dslot),
    .ras_count       (ras_count),
    .ras_underflow   (ras_underflow),
    .redirect_err    (redirect_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_tgt = 32'h0;
    m_bd = 1'b0; m_pend = 1'b0; m_uf = 1'b0; m_err = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] old_pc;
    old_pc = m_pc;
    m_uf   = 1'b0;
    m_err  = 1'b0;
    if (exc_valid) begin
      m_epc  = m_pend ? old_pc - 32'd4 : old_pc;
      m_bd   = m_pend;
      m_pc   = EXC;
      m_pend = 1'b0;
    end else if (eret) begin
      m_pc   = m_epc;
      m_pend = 1'b0;
    end else if (!stall) begin
      if (m_pend) begin
        m_pc   = m_tgt;
        m_pend = 1'b0;
        m_err  = redirect_valid | ret_pop;
      end else if (redirect_valid) begin
        if (redirect_delay) begin
          m_pc = old_pc + 32'd4; m_tgt = redirect_target; m_pend = 1'b1;
        end else begin
          m_pc = redirect_target;
        end
      end else if (ret_pop) begin
        m_pc = old_pc + 32'd4;
        if (m_ras.size() > 0) begin
          m_tgt  = m_ras.pop_back();
          m_pend = 1'b1;
        end else begin
          m_uf = 1'b1;
        end
      end else begin
        m_pc = old_pc + 32'd4;
      end
      if (call_push) begin
        m_ras.push_back(old_pc + 32'd8);
        if (m_ras.size() > DEPTH) m_ras.delete(0);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        pc,                   m_pc);
    check({tag, ".epc"},       epc,                  m_epc);
    check({tag, ".epc_bd"},    {31'd0, epc_bd},      {31'd0, m_bd});
    check({tag, ".in_dslot"},  {31'd0, in_dslot},    {31'd0, m_pend});
    check({tag, ".ras_count"}, {29'd0, ras_count},   32'(m_ras.size()));
    check({tag, ".underflow"}, {31'd0, ras_underflow}, {31'd0, m_uf});
    check({tag, ".redir_err"}, {31'd0, redirect_err},  {31'd0, m_err});
  endtask

  // Apply one cycle of requests; called at posedge+1, returns at the next posedge+1.
  task automatic step(input string tag, input logic st, input logic rv, input logic [31:0] rt,
                      input logic rd, input logic cp, input logic rp, input logic ex, input logic er);
    stall = st; redirect_valid = rv; redirect_target = rt; redirect_delay = rd;
    call_push = cp; ret_pop = rp; exc_valid = ex; eret = er;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #3;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset");
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; redirect_valid = 0; redirect_target = 0; redirect_delay = 0;
    call_push = 0; ret_pop = 0; exc_valid = 0; eret = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("por");
    check("por_pc", pc, 32'h0);

    // Free run and stall
    idle("run1"); idle("run2"); idle("run3");
    check("run_pc_c", pc, 32'hC);
    step("stall1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stall2", 1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("stall_hold", pc, 32'hC);
    idle("unstall");
    check("unstall_pc", pc, 32'h10);

    // Delayed redirect, then exception in the delay slot under stall, then eret
    step("dly", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dly_pc", pc, 32'h14);
    check("dly_slot", {31'd0, in_dslot}, 32'd1);
    step("exc", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("exc_pc", pc, EXC);
    check("exc_epc", epc, 32'h10);
    check("exc_bd", {31'd0, epc_bd}, 32'd1);
    step("eret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("eret_pc", pc, 32'h10);

    step("dly2", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("dly2_tgt");
    check("dly2_tgt_pc", pc, 32'h100);
    check("dly2_noslot", {31'd0, in_dslot}, 32'd0);
    step("imm", 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("imm_pc", pc, 32'h40);

    // Redirect in the delay slot is dropped
    step("dly3", 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("drop", 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drop_pc", pc, 32'h200);
    check("drop_err", {31'd0, redirect_err}, 32'd1);
    idle("drop_after");
    check("drop_err_clr", {31'd0, redirect_err}, 32'd0);

    // Reset in the middle of a delay slot with a live RAS entry
    step("pre_rst", 1'b0, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", {29'd0, ras_count}, 32'd1);
    apply_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_slot", {31'd0, in_dslot}, 32'd0);
    check("rst_cnt", {29'd0, ras_count}, 32'd0);

    // RAS: five calls overflow a four-deep stack, then four returns and an underflow
    for (int i = 0; i < 5; i++) step("call", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ras_full", {29'd0, ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_tgt;
      exp_tgt = 32'h18 - 32'(i * 4);
      step("ret", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle("ret_slot");
      check("ret_tgt", pc, exp_tgt);
    end
    step("ret_uf", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("uf_pulse", {31'd0, ras_underflow}, 32'd1);
    check("uf_pc", pc, 32'h10);
    idle("uf_after");
    check("uf_clr", {31'd0, ras_underflow}, 32'd0);

    // Wrap at the top of the address space
    step("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("wrap");
    check("wrap_pc", pc, 32'h0);
    check("wrap_err", {30'd0, redirect_err, ras_underflow}, 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic st, rv, rd, cp, rp, ex, er;
      logic [31:0] rt;
      st = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 39) == 0);
      er = ($urandom_range(0, 39) == 0);
      rv = ($urandom_range(0, 4) == 0);
      rd = $urandom_range(0, 1);
      cp = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 3) == 0);
      rt = $urandom & 32'hFFFF_FFFC;
      if (n == 700) apply_reset();
      step("rnd", st, rv, rt, rd, cp, rp, ex, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
